// File: rtl/halt_dump_streamer.sv
// halt_dump_streamer
// On a rising edge of the CPU halted flag, snapshots the eight CPU registers
// (A..G, Temp) and streams them as bytes, followed by a contiguous RAM window
// read through a one-cycle-latency read port. Output is a valid/ready byte
// stream with dump_last marking the final byte.
//
// Optional build macro: DUMP_CHECKSUM_EN
//   defined   -> a trailing byte (-sum of all streamed bytes) mod 256 is
//                appended and carries dump_last, so the whole stream sums to 0.
//   undefined -> dump_last rides on the last RAM byte.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for halted rising edge
// REGS     | presenting snapshot bytes 0..7, each held until accepted
// MEM_REQ  | ram_rd strobe high for one cycle at the current address
// MEM_WAIT | read data arrives, captured into dump_data
// MEM_OUT  | RAM byte held until accepted
// CSUM     | checksum byte held until accepted (checksum build only)
// DONE     | dump finished, wait for halted to drop before re-arming

module halt_dump_streamer #(
    parameter int ADDR_W     = 8,
    parameter int DUMP_START = 0,
    parameter int DUMP_LEN   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              halted,
    input  logic [63:0]       regs,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [7:0]        dump_data,
    output logic              dump_last,
    output logic              busy
);

    // Count needs to hold DUMP_LEN itself, which may equal 2**ADDR_W.
    localparam int                CNT_W      = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DUMP_START);
    localparam logic [CNT_W-1:0]  LEN_CNT    = CNT_W'(DUMP_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_REGS, S_MEM_REQ, S_MEM_WAIT, S_MEM_OUT, S_CSUM, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_REGS, S_MEM_REQ, S_MEM_WAIT, S_MEM_OUT, S_DONE
    } state_t;
`endif

    state_t            state_q;
    logic              halted_q;
    logic [63:0]       snap_q;
    logic [2:0]        reg_idx_q;
    logic [CNT_W-1:0]  remain_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_rd_q;
    logic              dump_valid_q;
    logic [7:0]        dump_data_q;
    logic              dump_last_q;
    logic              busy_q;

    logic              halt_rise_d;
    logic              accept_d;
    logic [2:0]        reg_idx_d;
    logic [7:0]        next_reg_byte_d;

    assign halt_rise_d     = halted & ~halted_q;
    assign accept_d        = dump_valid_q & dump_ready;
    assign reg_idx_d       = reg_idx_q + 3'd1;
    assign next_reg_byte_d = snap_q[{reg_idx_d, 3'b000} +: 8];

`ifdef DUMP_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] csum_d;

    // Checksum byte makes the sum of every streamed byte equal zero.
    assign csum_d = 8'd0 - (sum_q + dump_data_q);

    // Running sum of accepted bytes, cleared when a new dump starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 8'd0;
        end else if (state_q == S_IDLE && halt_rise_d) begin
            sum_q <= 8'd0;
        end else if (accept_d) begin
            sum_q <= sum_q + dump_data_q;
        end
    end
`endif

    // Registered copy of halted for edge detection. Resets high so a CPU that
    // is already halted when reset releases does not look like a new halt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halted_q <= 1'b1;
        end else begin
            halted_q <= halted;
        end
    end

    // Dump sequencer with registered stream and RAM-port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            snap_q       <= 64'd0;
            reg_idx_q    <= 3'd0;
            remain_q     <= '0;
            ram_addr_q   <= '0;
            ram_rd_q     <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= 8'd0;
            dump_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ram_rd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (halt_rise_d) begin
                        snap_q       <= regs;
                        reg_idx_q    <= 3'd0;
                        remain_q     <= LEN_CNT;
                        dump_data_q  <= regs[7:0];
                        dump_valid_q <= 1'b1;
                        dump_last_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_REGS;
                    end
                end
                S_REGS: begin
                    if (accept_d) begin
                        if (reg_idx_q == 3'd7) begin
                            dump_valid_q <= 1'b0;
                            ram_addr_q   <= START_ADDR;
                            ram_rd_q     <= 1'b1;
                            state_q      <= S_MEM_REQ;
                        end else begin
                            reg_idx_q   <= reg_idx_d;
                            dump_data_q <= next_reg_byte_d;
                        end
                    end
                end
                S_MEM_REQ: begin
                    state_q <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    dump_data_q  <= ram_rdata;
                    dump_valid_q <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    dump_last_q  <= 1'b0;
`else
                    dump_last_q  <= (remain_q == CNT_ONE);
`endif
                    state_q      <= S_MEM_OUT;
                end
                S_MEM_OUT: begin
                    if (accept_d) begin
                        remain_q <= remain_q - CNT_ONE;
                        if (remain_q == CNT_ONE) begin
`ifdef DUMP_CHECKSUM_EN
                            dump_data_q  <= csum_d;
                            dump_valid_q <= 1'b1;
                            dump_last_q  <= 1'b1;
                            state_q      <= S_CSUM;
`else
                            dump_valid_q <= 1'b0;
                            dump_last_q  <= 1'b0;
                            busy_q       <= 1'b0;
                            state_q      <= S_DONE;
`endif
                        end else begin
                            dump_valid_q <= 1'b0;
                            ram_addr_q   <= ram_addr_q + 1'b1;
                            ram_rd_q     <= 1'b1;
                            state_q      <= S_MEM_REQ;
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                S_CSUM: begin
                    if (accept_d) begin
                        dump_valid_q <= 1'b0;
                        dump_last_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (!halted) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;
    assign dump_last  = dump_last_q;
    assign busy       = busy_q;

endmodule
